test4_soc_key_pio: RTL and testbench

//  Avalon-MM slave input PIO: the receive-side counterpart of the SoC's LED output PIO.

---
 rtl/test4_soc_key_pio_if.sv | 37 +++
 rtl/test4_soc_key_pio.sv | 143 ++++++++++++++
 tb/tb_test4_soc_key_pio.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/test4_soc_key_pio_if.sv
// rtl/test4_soc_key_pio_if.sv - Avalon-MM slave register bus bundle for the key/switch input PIO
//
// Purpose: groups the HPS-bridge side of the key PIO into one bundle.
//   address    [1:0]  word address (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] combinational read data, zero-extended
//   irq               level interrupt from the PIO
// The master modport drives the request side; the slave modport drives readdata and irq.

interface test4_soc_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/test4_soc_key_pio.sv
// rtl/test4_soc_key_pio.sv - Avalon-MM input PIO with synchroniser, debounce, edge capture and IRQ
//
// Purpose: samples asynchronous key/switch lines, synchronises and debounces each one,
// latches edges into a sticky capture register and raises a level interrupt for unmasked
// captured edges. Zero-wait-state slave, read latency 0.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   in_port  in   [WIDTH-1:0] asynchronous external inputs
//   bus      slave modport: address/chipselect/write_n/writedata in, readdata/irq out
// Parameters:
//   WIDTH            number of input lines (1..32)
//   DEBOUNCE_CYCLES  extra stable cycles needed before the filtered value follows the input
//   EDGE_TYPE        0 rising, 1 falling, 2 any edge sets the capture bit
//   IN_RESET         reset value of the synchroniser and filter stages

module test4_soc_key_pio #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] IN_RESET        = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    test4_soc_key_pio_if.slave   bus
);

    // $clog2(1) is 0, so a zero debounce still needs a one-bit counter.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             mask_wr;
    logic             cap_wr;
    logic [31:0]      rd_word;

    assign wdata   = bus.writedata[WIDTH-1:0];
    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign mask_wr = wr_en && (bus.address == ADDR_MASK);
    assign cap_wr  = wr_en && (bus.address == ADDR_CAPTURE);

    // Two-flop synchroniser per line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET;
            sync2 <= IN_RESET;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Per-line debounce: the filtered value only follows sync2 after it has differed for
    // DEBOUNCE_CYCLES+1 consecutive samples. Any agreeing sample restarts the count, and the
    // count is cleared when it fires, so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= IN_RESET;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d <= IN_RESET;
        end else begin
            filt_d <= filt;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_hit = filt & ~filt_d;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_hit = ~filt & filt_d;
        end else begin : g_any
            assign edge_hit = filt ^ filt_d;
        end
    endgenerate

    // Write-one-to-clear capture; a new edge on the same cycle overrides the clear so the
    // event is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else if (cap_wr) begin
            edge_capture <= (edge_capture & ~wdata) | edge_hit;
        end else begin
            edge_capture <= edge_capture | edge_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (mask_wr) begin
            irq_mask <= wdata;
        end
    end

    assign bus.irq = |(edge_capture & irq_mask);

    // Zero-latency read mux; unused upper bits and the reserved word read as zero.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_DATA:    rd_word[WIDTH-1:0] = filt;
            ADDR_MASK:    rd_word[WIDTH-1:0] = irq_mask;
            ADDR_CAPTURE: rd_word[WIDTH-1:0] = edge_capture;
            default:      rd_word = '0;
        endcase
    end

    assign bus.readdata = rd_word;

endmodule

// File: tb/tb_test4_soc_key_pio.sv
// tb/tb_test4_soc_key_pio.sv - self-checking bench for the key PIO (rising, falling and any-edge builds)

module tb_test4_soc_key_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test4_soc_key_pio_if bus0 ();
    test4_soc_key_pio_if bus1 ();
    test4_soc_key_pio_if bus2 ();

    assign bus0.address = address;  assign bus0.chipselect = chipselect;
    assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
    assign bus1.address = address;  assign bus1.chipselect = chipselect;
    assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
    assign bus2.address = address;  assign bus2.chipselect = chipselect;
    assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

    test4_soc_key_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IN_RESET(8'h00)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus0)
    );
    test4_soc_key_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IN_RESET(8'h00)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus1)
    );
    test4_soc_key_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IN_RESET(8'h00)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus2)
    );

    typedef struct {
        logic [7:0]  in;
        bit          cs;
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        int          waits;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic set_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        set_read(2'd0); check({tag, " addr0"}, bus0.readdata, 32'h0);
        set_read(2'd1); check({tag, " addr1"}, bus0.readdata, 32'h0);
        set_read(2'd2); check({tag, " addr2"}, bus0.readdata, 32'h0);
        set_read(2'd3); check({tag, " addr3"}, bus0.readdata, 32'h0);
        check({tag, " irq"}, {31'b0, bus0.irq}, 32'h0);
    endtask

    initial begin
        //            in     cs wr waddr wdata   wait raddr exp_rd  irq
        vecs[0]  = '{8'h01, 1, 1, 2'd2, 32'h01,  0,  2'd3, 32'h01, 1}; // unmask captured bit0
        vecs[1]  = '{8'h01, 1, 1, 2'd3, 32'h00,  0,  2'd3, 32'h01, 1}; // clear with zero: no change
        vecs[2]  = '{8'h01, 1, 1, 2'd3, 32'h01,  0,  2'd3, 32'h00, 0}; // write-1-clear
        vecs[3]  = '{8'h01, 1, 1, 2'd0, 32'hFF,  0,  2'd0, 32'h01, 0}; // data write ignored
        vecs[4]  = '{8'h01, 1, 1, 2'd1, 32'hFF,  0,  2'd1, 32'h00, 0}; // reserved write ignored
        vecs[5]  = '{8'h01, 0, 1, 2'd2, 32'h55,  0,  2'd2, 32'h01, 0}; // no chipselect
        vecs[6]  = '{8'h01, 1, 0, 2'd2, 32'h55,  0,  2'd2, 32'h01, 0}; // write_n high
        vecs[7]  = '{8'h03, 0, 0, 2'd0, 32'h00,  8,  2'd3, 32'h02, 0}; // bit1 rise, masked off
        vecs[8]  = '{8'h03, 1, 1, 2'd2, 32'h02,  0,  2'd3, 32'h02, 1}; // unmask raises irq
        vecs[9]  = '{8'h03, 1, 1, 2'd3, 32'h02,  0,  2'd3, 32'h00, 0};
        vecs[10] = '{8'h03, 1, 1, 2'd2, 32'hFF,  0,  2'd2, 32'hFF, 0};
        vecs[11] = '{8'h03, 1, 1, 2'd2, 32'h00,  0,  2'd2, 32'h00, 0};
        vecs[12] = '{8'h03, 0, 0, 2'd0, 32'h00,  0,  2'd0, 32'h03, 0};

        reset_n    = 1'b0;
        in_port    = 8'h00;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) tick();
        check_reset_state("init_reset");
        reset_n = 1'b1;
        tick();

        // Debounce timing: in_port changes, filt follows at edge 7, capture at edge 8.
        in_port = 8'h01;
        set_read(2'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("debounce edge%0d addr0", k), bus0.readdata, (k >= 7) ? 32'h01 : 32'h00);
        end
        set_read(2'd3);
        check("capture before edge8", bus0.readdata, 32'h00);
        tick();
        check("capture edge8 rise", bus0.readdata, 32'h01);
        check("capture edge8 fall-build", bus1.readdata, 32'h00);
        check("capture edge8 any-build", bus2.readdata, 32'h01);

        // Glitch: bit2 high for three cycles only.
        in_port = 8'h05;
        repeat (3) tick();
        in_port = 8'h01;
        repeat (12) tick();
        set_read(2'd0); check("glitch addr0", bus0.readdata, 32'h01);
        set_read(2'd3); check("glitch capture", bus0.readdata, 32'h01);
        check("glitch irq", {31'b0, bus0.irq}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            in_port    = vecs[i].in;
            address    = vecs[i].waddr;
            writedata  = vecs[i].wdata;
            chipselect = vecs[i].cs;
            write_n    = ~vecs[i].wr;
            tick();
            chipselect = 1'b0;
            write_n    = 1'b1;
            repeat (vecs[i].waits) tick();
            set_read(vecs[i].raddr);
            check($sformatf("vec%0d readdata", i), bus0.readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d irq", i), {31'b0, bus0.irq}, {31'b0, vecs[i].exp_irq});
        end

        // Falling edges on bits 0 and 1 across the three builds.
        bus_write(2'd3, 32'hFF);
        in_port = 8'h00;
        repeat (10) tick();
        set_read(2'd3);
        check("fall capture rise-build", bus0.readdata, 32'h00);
        check("fall capture fall-build", bus1.readdata, 32'h03);
        check("fall capture any-build", bus2.readdata, 32'h03);
        bus_write(2'd3, 32'hFF);
        set_read(2'd3);
        check("fall-build cleared", bus1.readdata, 32'h00);

        // Collision: bit1 capture set and write-1-clear on the same edge.
        in_port = 8'h02;
        repeat (7) tick();
        set_read(2'd0); check("collision filt", bus0.readdata, 32'h02);
        set_read(2'd3); check("collision pre-capture", bus0.readdata, 32'h00);
        bus_write(2'd3, 32'h02);
        set_read(2'd3); check("collision set wins", bus0.readdata, 32'h02);
        check("collision irq masked", {31'b0, bus0.irq}, 32'h0);
        bus_write(2'd2, 32'h02);
        check("collision unmask irq", {31'b0, bus0.irq}, 32'h1);
        bus_write(2'd3, 32'h02);
        set_read(2'd3); check("collision later clear", bus0.readdata, 32'h00);
        check("collision irq cleared", {31'b0, bus0.irq}, 32'h0);

        // Reset mid-activity with an input that differs from IN_RESET.
        bus_write(2'd2, 32'hFF);
        in_port = 8'h0F;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (12) tick();
        set_read(2'd0); check("post-reset mismatch filt", bus0.readdata, 32'h0F);
        set_read(2'd3); check("post-reset mismatch capture", bus0.readdata, 32'h0F);

        // Reset with the input already at IN_RESET: nothing is reported.
        in_port = 8'h00;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (12) tick();
        set_read(2'd0); check("post-reset quiet filt", bus0.readdata, 32'h00);
        set_read(2'd3); check("post-reset quiet capture", bus0.readdata, 32'h00);
        check("post-reset quiet irq", {31'b0, bus0.irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
